// File: rtl/mod_div_pkg.sv
// Shared types for the iterative divide unit.
// No logic; constants and FSM state encoding only.
// Not applicable: no handshake lives here.
package mod_div_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod_div_datapath.sv
// Holds the working remainder, divisor and running quotient; one subtract per step.
// Latency: registers update on the edge where load or step is high.
// No backpressure: the controlling FSM decides when to load or step.
module mod_div_datapath
    import mod_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ge,
    output logic             div_zero,
    output logic [WIDTH-1:0] rem,
    output logic [WIDTH-1:0] quot
);

    logic [WIDTH-1:0] rem_q,  rem_d;
    logic [WIDTH-1:0] div_q,  div_d;
    logic [WIDTH-1:0] quot_q, quot_d;

    // Status back to the FSM: can we subtract again, and is the divisor zero.
    always_comb begin
        ge       = (rem_q >= div_q);
        div_zero = (div_q == '0);
    end

    // Load captures the operands; step performs one restoring-free subtraction.
    always_comb begin
        rem_d  = rem_q;
        div_d  = div_q;
        quot_d = quot_q;
        if (load) begin
            rem_d  = a;
            div_d  = b;
            quot_d = '0;
        end else if (step) begin
            rem_d  = rem_q - div_q;
            quot_d = quot_q + WIDTH'(1);
        end
    end

    // Working registers, cleared by reset so an aborted operation leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            div_q  <= '0;
            quot_q <= '0;
        end else begin
            rem_q  <= rem_d;
            div_q  <= div_d;
            quot_q <= quot_d;
        end
    end

    assign rem  = rem_q;
    assign quot = quot_q;

endmodule

// File: rtl/mod_div_unit.sv
// Unsigned quotient/remainder by repeated subtraction, with divide-by-zero flag.
// Latency: q+1 cycles from accepted start to DONE entry (1 cycle for b==0 or a<b).
// start is only honoured in IDLE; requests while busy or done are dropped.
module mod_div_unit
    import mod_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;

    logic             load;
    logic             step;
    logic             ge;
    logic             div_zero;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;

    mod_div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .a        (a),
        .b        (b),
        .ge       (ge),
        .div_zero (div_zero),
        .rem      (rem),
        .quot     (quot)
    );

    // Next state, datapath controls, and result capture on DONE entry.
    always_comb begin
        state_d     = state_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        load        = 1'b0;
        step        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    dbz_d   = 1'b0;
                    state_d = ITER;
                end
            end
            ITER: begin
                if (div_zero) begin
                    // Divisor zero: saturate quotient, hand back the dividend.
                    dbz_d       = 1'b1;
                    quotient_d  = '1;
                    remainder_d = rem;
                    state_d     = DONE;
                end else if (ge) begin
                    step = 1'b1;
                end else begin
                    quotient_d  = quot;
                    remainder_d = rem;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == ITER);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/mod_div_unit.md
# mod_div_unit

Parametrised iterative modulo/division engine that computes quotient and remainder of two unsigned operands by repeated subtraction. It combines control FSM and datapath in one block, adds a start/busy/done handshake and divide-by-zero detection, and scales to any operand width. It sits as a multi-cycle execution unit behind the processor's operation decoder.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clock clk
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  dividend, unsigned, captured on accepted start
- b  input  WIDTH  divisor, unsigned, captured on accepted start
- busy  output  1  high while an operation is in progress (ITER)
- done  output  1  one-cycle pulse: results valid
- quotient  output  WIDTH  a / b
- remainder  output  WIDTH  a mod b
- div_by_zero  output  1  set when captured b == 0; held with results

## Operation
- States: IDLE, ITER, DONE.
- IDLE: busy=0. If start=1 at clock edge: rem_r<=a, div_r<=b, quot_r<=0, div_by_zero<=0, state<=ITER. Otherwise hold all outputs.
- ITER: busy=1. Each edge, in priority order:
  - div_r==0: div_by_zero<=1, quotient<={WIDTH{1'b1}}, remainder<=rem_r (original a), state<=DONE.
  - rem_r >= div_r: rem_r<=rem_r-div_r, quot_r<=quot_r+1, stay.
  - else: quotient<=quot_r, remainder<=rem_r, state<=DONE.
- DONE: done=1 for exactly one cycle, busy=0, state<=IDLE unconditionally; start in DONE is ignored.
- Arithmetic unsigned, WIDTH bits; comparison unsigned; quot_r cannot overflow (b≥1 ⇒ q ≤ a).
- quotient/remainder/div_by_zero are registered and hold last result until the next accepted start clears div_by_zero; quotient/remainder change only on DONE entry.
- start while busy or in DONE: ignored, no effect on operation or outputs.
- a/b changes after capture: no effect.

## Timing
- Reset (async, any state, including mid-ITER): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers 0; in-flight operation discarded.
- Start accepted at edge E0; busy high from E0.
- Normal case with quotient q: q subtracting edges E1..Eq, DONE entry at E(q+1); done high in cycle after E(q+1); latency q+1 cycles; worst case 2^WIDTH cycles (a=max, b=1).
- b==0: DONE entry at E1, latency 1.
- a<b: DONE entry at E1, quotient=0, remainder=a.
- Back-to-back: earliest next start accepted at edge following the done cycle (IDLE).
- busy and done never high simultaneously.

## Structure
- Package mod_div_pkg: state typedef (IDLE, ITER, DONE as 2-bit enum), default WIDTH constant.
- Sub-module mod_div_datapath: rem/div/quot registers, subtractor, comparator; outputs ge (rem_r>=div_r) and div_zero flags to the FSM; controls load/step from FSM. FSM and output registers stay in mod_div_unit.

## Test plan
- WIDTH=8, a=17, b=5, start pulse → busy for 4 cycles, done one cycle later with quotient=3, remainder=2, div_by_zero=0.
- a=3, b=7 → done after 1 cycle, quotient=0, remainder=3.
- a=42, b=0 → done after 1 cycle, div_by_zero=1, quotient=8'hFF, remainder=42; next start with b=3 clears div_by_zero, result 14/0.
- a=255, b=1 → quotient=255, remainder=0, latency 256 cycles; a=255, b=255 → 1/0.
- start=1 held continuously with changing a/b during ITER and DONE → first capture only computed; next operation accepted first cycle in IDLE.
- Assert reset mid-ITER (a=200, b=3, after 10 cycles) → all outputs 0 immediately, IDLE; new start a=10, b=4 → quotient=2, remainder=2.
